// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared debug command and controller state encodings
package pipe_ctrl_pkg;
    typedef enum logic [1:0] {CMD_NOP = 2'b00, CMD_RUN = 2'b01, CMD_STEP = 2'b10, CMD_HALT = 2'b11} cmd_e;
    typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_RUN = 2'b01, ST_STEP = 2'b10, ST_DONE = 2'b11} state_e;
    localparam int NB_ADDR_DEF = 5;
endpackage

// File: rtl/pipe_exec_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use detector for the ID stage
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int NB_ADDR = NB_ADDR_DEF
) (
    input  logic               idex_mem_read,
    input  logic [NB_ADDR-1:0] idex_rt,
    input  logic [NB_ADDR-1:0] ifid_rs,
    input  logic [NB_ADDR-1:0] ifid_rt,
    output logic               hz
);
    // $zero is never a real dependency, so a load into it cannot stall
    assign hz = idex_mem_read && (idex_rt != '0) && (idex_rt == ifid_rs || idex_rt == ifid_rt);
endmodule

// File: rtl/pipe_exec_ctrl.sv
// pipe_exec_ctrl: run/step/halt sequencing of the pipeline clock enable,
// executed-cycle counter and load-use stall/flush generation
module pipe_exec_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NB_REG  = 32,
    parameter int NB_ADDR = NB_ADDR_DEF,
    parameter int NB_CYC  = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_cmd_valid,
    input  logic [1:0]         i_cmd,
    output logic               o_cmd_ready,
    input  logic               i_halt_wb,
    input  logic               i_idex_mem_read,
    input  logic [NB_ADDR-1:0] i_idex_rt,
    input  logic [NB_ADDR-1:0] i_ifid_rs,
    input  logic [NB_ADDR-1:0] i_ifid_rt,
    output logic               o_dunit_clk_en,
    output logic               o_pc_write,
    output logic               o_ifid_write,
    output logic               o_idex_flush,
    output logic [1:0]         o_state,
    output logic [NB_CYC-1:0]  o_cycle_cnt,
    output logic               o_done
);
    if (NB_REG < 1 || NB_CYC < 1) begin : g_param_chk
        $error("pipe_exec_ctrl: NB_REG and NB_CYC must be positive");
    end

    state_e            state_q, state_d;
    logic              accept, hz;
    logic [NB_CYC-1:0] cnt_q;

    assign o_cmd_ready    = (state_q == ST_IDLE) || (state_q == ST_RUN);
    assign o_dunit_clk_en = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign o_done         = (state_q == ST_DONE);
    assign o_state        = state_q;
    assign o_cycle_cnt    = cnt_q;
    assign accept         = i_cmd_valid && o_cmd_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (o_dunit_clk_en && cnt_q != '1)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    // halt_wb is only meaningful while the pipeline is actually advancing
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: state_d = !accept ? ST_IDLE :
                               i_cmd == CMD_RUN  ? ST_RUN :
                               i_cmd == CMD_STEP ? ST_STEP : ST_IDLE;
            ST_RUN:  state_d = i_halt_wb ? ST_DONE :
                               (accept && i_cmd == CMD_HALT) ? ST_IDLE : ST_RUN;
            ST_STEP: state_d = i_halt_wb ? ST_DONE : ST_IDLE;
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    hazard_detect #(.NB_ADDR(NB_ADDR)) u_hazard (
        .idex_mem_read(i_idex_mem_read),
        .idex_rt      (i_idex_rt),
        .ifid_rs      (i_ifid_rs),
        .ifid_rt      (i_ifid_rt),
        .hz           (hz)
    );

    assign o_pc_write   = ~hz;
    assign o_ifid_write = ~hz;
    assign o_idex_flush = hz;
endmodule

// File: tb/tb_pipe_exec_ctrl.sv
// tb_pipe_exec_ctrl: directed checks of run/step/halt sequencing, counter and hazard unit
module tb_pipe_exec_ctrl;
    import pipe_ctrl_pkg::*;

    logic        clk = 0;
    logic        rst = 1, v = 0, halt_wb = 0;
    logic [1:0]  cmd = CMD_NOP;
    logic        mr = 0;
    logic [4:0]  ex_rt = 0, id_rs = 0, id_rt = 0;
    logic        rdy, en, pcw, ifw, fl, done;
    logic [1:0]  st;
    logic [31:0] cnt;
    logic        rst4 = 1, v4 = 0;
    logic [1:0]  cmd4 = CMD_NOP;
    logic        rdy4, en4, pcw4, ifw4, fl4, done4;
    logic [1:0]  st4;
    logic [3:0]  cnt4;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    pipe_exec_ctrl dut (
        .i_clk(clk), .i_reset(rst), .i_cmd_valid(v), .i_cmd(cmd), .o_cmd_ready(rdy),
        .i_halt_wb(halt_wb), .i_idex_mem_read(mr), .i_idex_rt(ex_rt), .i_ifid_rs(id_rs),
        .i_ifid_rt(id_rt), .o_dunit_clk_en(en), .o_pc_write(pcw), .o_ifid_write(ifw),
        .o_idex_flush(fl), .o_state(st), .o_cycle_cnt(cnt), .o_done(done)
    );

    pipe_exec_ctrl #(.NB_CYC(4)) dut4 (
        .i_clk(clk), .i_reset(rst4), .i_cmd_valid(v4), .i_cmd(cmd4), .o_cmd_ready(rdy4),
        .i_halt_wb(1'b0), .i_idex_mem_read(1'b0), .i_idex_rt(5'd0), .i_ifid_rs(5'd0),
        .i_ifid_rt(5'd0), .o_dunit_clk_en(en4), .o_pc_write(pcw4), .o_ifid_write(ifw4),
        .o_idex_flush(fl4), .o_state(st4), .o_cycle_cnt(cnt4), .o_done(done4)
    );

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [1:0] c);
        v = 1; cmd = c;
        tick();
        v = 0; cmd = CMD_NOP;
    endtask

    task automatic chk_ctrl(input string tag, input logic [1:0] s, input logic e, input logic r,
                            input logic d, input logic [31:0] c);
        chk({tag, "_state"}, 32'(st), 32'(s));
        chk({tag, "_en"}, 32'(en), 32'(e));
        chk({tag, "_ready"}, 32'(rdy), 32'(r));
        chk({tag, "_done"}, 32'(done), 32'(d));
        chk({tag, "_cnt"}, cnt, c);
    endtask

    task automatic chk_hz(input string tag, input logic h);
        #1;
        chk({tag, "_pcw"}, 32'(pcw), 32'(!h));
        chk({tag, "_ifw"}, 32'(ifw), 32'(!h));
        chk({tag, "_flush"}, 32'(fl), 32'(h));
    endtask

    initial begin
        tick(2);
        rst = 0;
        chk_ctrl("reset", ST_IDLE, 0, 1, 0, 0);
        tick(10);
        chk_ctrl("idle10", ST_IDLE, 0, 1, 0, 0);

        send(CMD_STEP);
        chk_ctrl("step1_in", ST_STEP, 1, 0, 0, 0);
        tick();
        chk_ctrl("step1_out", ST_IDLE, 0, 1, 0, 1);
        send(CMD_STEP); tick();
        send(CMD_STEP); tick();
        chk_ctrl("step3", ST_IDLE, 0, 1, 0, 3);

        send(CMD_RUN);
        chk_ctrl("run_start", ST_RUN, 1, 1, 0, 3);
        tick(9);
        chk_ctrl("run_mid", ST_RUN, 1, 1, 0, 12);
        send(CMD_HALT);
        chk_ctrl("run_halt", ST_IDLE, 0, 1, 0, 13);

        send(CMD_RUN);
        send(CMD_STEP);
        chk_ctrl("run_ign_step", ST_RUN, 1, 1, 0, 14);
        send(CMD_HALT);
        chk_ctrl("run2_halt", ST_IDLE, 0, 1, 0, 15);

        halt_wb = 1; tick(); halt_wb = 0;
        chk_ctrl("idle_haltwb", ST_IDLE, 0, 1, 0, 15);

        send(CMD_RUN);
        tick(3);
        halt_wb = 1;
        send(CMD_HALT);
        halt_wb = 0;
        chk_ctrl("done", ST_DONE, 0, 0, 1, 19);
        send(CMD_RUN); send(CMD_RUN);
        chk_ctrl("done_sticky", ST_DONE, 0, 0, 1, 19);

        rst = 1; tick(); rst = 0;
        chk_ctrl("done_reset", ST_IDLE, 0, 1, 0, 0);

        send(CMD_STEP);
        halt_wb = 1; tick(); halt_wb = 0;
        chk_ctrl("step_haltwb", ST_DONE, 0, 0, 1, 1);
        rst = 1; tick(); rst = 0;

        send(CMD_RUN);
        tick(2);
        chk_ctrl("run_pre_rst", ST_RUN, 1, 1, 0, 2);
        rst = 1; tick(); rst = 0;
        chk_ctrl("run_rst", ST_IDLE, 0, 1, 0, 0);

        mr = 1; ex_rt = 8; id_rs = 8; id_rt = 3;
        chk_hz("hz_rs", 1);
        ex_rt = 0; id_rs = 0; id_rt = 0;
        chk_hz("hz_zero", 0);
        ex_rt = 8; id_rs = 2; id_rt = 8;
        chk_hz("hz_rt", 1);
        id_rt = 9;
        chk_hz("hz_nomatch", 0);
        mr = 0; id_rs = 8; id_rt = 8;
        chk_hz("hz_noload", 0);

        tick();
        rst4 = 0;
        v4 = 1; cmd4 = CMD_RUN; tick(); v4 = 0; cmd4 = CMD_NOP;
        tick(20);
        chk("sat_cnt", 32'(cnt4), 32'd15);
        chk("sat_en", 32'(en4), 32'd1);
        rst4 = 1; tick(); rst4 = 0;
        chk("sat_rst_en", 32'(en4), 32'd0);
        chk("sat_rst_cnt", 32'(cnt4), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_exec_ctrl.md
Name: pipe_exec_ctrl

Overview:
Execution controller for the 5-stage MIPS pipeline. It sequences the debug-unit clock enable that gates every pipeline register, including IF_ID, PC, ID_EX, EX_MEM and MEM_WB, for run, single-step and halt operation. It detects load-use hazards and produces the stall/flush controls: PC write, IF_ID write, and the ID_EX bubble. It sits between the debug unit (UART command decoder) and the pipeline top level.

Parameters:
NB_REG, 32, datapath width (reported PC/counter alignment only)
NB_ADDR, 5, register-file address width
NB_CYC, 32, width of executed-cycle counter

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_cmd_valid  in  1  debug command strobe
i_cmd  in  2  00 NOP, 01 RUN, 10 STEP, 11 HALT
o_cmd_ready  out  1  command accepted when valid&ready
i_halt_wb  in  1  HALT instruction retiring in WB this cycle
i_idex_mem_read  in  1  instruction in EX is a load
i_idex_rt  in  NB_ADDR  load destination in EX
i_ifid_rs  in  NB_ADDR  rs of instruction in ID
i_ifid_rt  in  NB_ADDR  rt of instruction in ID
o_dunit_clk_en  out  1  pipeline-wide advance enable
o_pc_write  out  1  PC update enable (0 = stall)
o_ifid_write  out  1  IF_ID write enable (0 = stall)
o_idex_flush  out  1  insert bubble into ID_EX
o_state  out  2  00 IDLE, 01 RUN, 10 STEP, 11 DONE
o_cycle_cnt  out  NB_CYC  enabled cycles executed
o_done  out  1  program finished (state DONE)

Behaviour:
- Reset state: IDLE, o_dunit_clk_en=0, o_cycle_cnt=0, o_done=0, o_cmd_ready=1. Reset mid-RUN/STEP aborts immediately with no extra enabled cycle.
- FSM, Moore: o_dunit_clk_en = (state==RUN || state==STEP).
- IDLE:
  - Accepted RUN -> RUN.
  - Accepted STEP -> STEP.
  - HALT and NOP are accepted and ignored.
- RUN:
  - o_cmd_ready=1; only HALT is acted on, RUN/STEP/NOP are accepted and ignored.
  - HALT -> IDLE.
  - i_halt_wb=1 -> DONE. If HALT and i_halt_wb occur in the same cycle, DONE wins.
- STEP:
  - Exactly one enabled cycle, then -> IDLE, or -> DONE if i_halt_wb=1 in that cycle.
  - o_cmd_ready=0.
- DONE:
  - o_done=1, o_cmd_ready=0, clock enable stays 0.
  - Exit only by i_reset.
- i_halt_wb is ignored while o_dunit_clk_en=0.
- Latency: command accepted at edge N -> o_dunit_clk_en high in cycle N+1. i_halt_wb seen in cycle M -> enable low from cycle M+1.
- o_cycle_cnt: increments by 1 every cycle with o_dunit_clk_en=1. Saturates at all-ones, no wrap.
- Load-use hazard, combinational:
  - hz = i_idex_mem_read && (i_idex_rt != 0) && (i_idex_rt == i_ifid_rs || i_idex_rt == i_ifid_rt).
  - o_pc_write = ~hz, o_ifid_write = ~hz, o_idex_flush = hz.
  - Independent of FSM state; the pipeline registers also qualify these with o_dunit_clk_en, so a hazard during IDLE has no effect.
  - During STEP with hz=1, the step consumes the bubble cycle.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - command encodings (CMD_NOP/RUN/STEP/HALT);
  - state encodings (ST_IDLE/RUN/STEP/DONE);
  - NB_ADDR default.
- One sub-module: hazard_detect, the combinational load-use unit reused by the forwarding tests.
- FSM and counter live in the top.

Test Plan:
- Reset, then idle 10 cycles -> o_dunit_clk_en=0, o_cycle_cnt=0, o_state=00, o_cmd_ready=1.
- STEP accepted at cycle 5 -> enable high in cycle 6 only. o_state 10 then 00. o_cycle_cnt=1. Three steps -> count=3.
- RUN at cycle 2, HALT at cycle 12 -> enable high cycles 3..12 (count=10). Back in IDLE; a second RUN resumes counting from 10.
- RUN, then i_halt_wb pulse at cycle 20 together with cmd HALT -> state DONE, o_done=1, enable low from 21. Further RUN is ignored (o_cmd_ready=0) until reset.
- idex_mem_read=1, idex_rt=8:
  - ifid_rs=8 -> pc_write=0, ifid_write=0, idex_flush=1.
  - idex_rt=0 with ifid_rs=0 -> no hazard.
  - ifid_rt=8 -> hazard.
  - mem_read=0 -> no hazard.
- Counter saturation with NB_CYC=4: RUN 20 cycles -> o_cycle_cnt holds 15. Reset mid-RUN -> next cycle enable=0, count=0.
